bcd_scheduler: RTL and testbench
================================

# bcd_scheduler

Round-robin scheduler that shares one binary-to-BCD converter (16-bit signed in, 21-bit `{sign, five, four, three, two, one}` out, active-low `wr` start, no done flag) among several front-panel display sources. It grants one requester at a time, issues a single start strobe, times the converter's fixed latency, captures the result and returns it with a channel tag. It sits between the front-panel register taps and the converter instance at the user-interface top level.

## Interface
- `WIDTH`, 16: converter data width; max 16; must equal the converter's `width`.
- `NREQ`, 4: number of requesters; legal 2..8.
- `CONV_LAT`, localparam = 2*WIDTH+2 (34): cycles from the converter sampling `wr` low to result sampleable.
- `CHW`, localparam = clog2(NREQ): channel tag width.

- `clk`  in  1  system clock, full speed, shared with converter.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  NREQ  per-channel request level; held until matching `done`.
- `data_in`  in  NREQ*WIDTH  channel i operand at `[i*WIDTH +: WIDTH]`, two's complement.
- `done`  out  NREQ  one-cycle pulse on the channel whose result is in `result`.
- `result`  out  21  last captured converter output; held until next capture.
- `result_ch`  out  CHW  channel that owns `result`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `conv_wr`  out  1  to converter `wr`; active low, registered.
- `conv_data`  out  WIDTH  to converter `data_in`; registered.
- `conv_res`  in  21  from converter `data_out`.

## Operation
- States: FLUSH, IDLE, ISSUE, WAIT.
- Reset values: state=FLUSH, `conv_wr`=1, `conv_data`=0, `done`=0, `result`=0, `result_ch`=0, `busy`=1, RR pointer=0, counter=CONV_LAT-1.
- FLUSH: converter has no reset and may be mid-conversion; hold `conv_wr` high, count CONV_LAT edges, then IDLE. Ignore `req`.
- IDLE: if any `req` bit is set, grant the first set bit searching upward from the pointer, wrapping modulo NREQ. At the grant edge: latch `data_in` slice into `conv_data`, latch the tag, set `conv_wr`=0, go to ISSUE, set pointer = grant+1 mod NREQ.
- ISSUE (one cycle): converter samples `conv_wr` low. At its end: `conv_wr`=1, counter=CONV_LAT-1, go to WAIT.
- WAIT: decrement each edge. At the edge where counter==0: `result`<=`conv_res`, `result_ch`<=tag, `done[tag]`<=1 for one cycle, go to IDLE.
- `conv_wr` is low for exactly one cycle per conversion and never low outside ISSUE; no second strobe while the converter is busy.
- `req[i]` dropping after grant does not abort the conversion; `done[i]` still pulses.
- `req[i]` still high after `done[i]` is re-eligible, but the pointer has already moved past it.
- `rst_n` low at any point aborts and returns to reset values. No `done` is issued for the aborted grant. FLUSH then always runs its full length.

## Timing
- Grant at edge G → `conv_wr` low during cycle G..G+1 → converter start at G+1 → capture at edge G+35 → `done`, `result` visible after G+35.
- Throughput is one conversion per 36 cycles. The earliest next grant is at edge G+36.
- Result latency from `req` seen at G is 35 cycles. Worst-case wait for a channel is NREQ*36 cycles.
- After `rst_n` deasserts, IDLE is entered at the 34th edge and the first grant is possible at the 35th.

## Structure
- Shared package `neptune_ui_pkg`: state encoding, `BCD_OUT_W`=21, function `conv_lat(width)`=2*width+2.
- Sub-module `rr_arbiter` (NREQ, pointer in, req in → one-hot grant and encoded index, combinational).
- The converter is not instantiated here; the UI top level wires `conv_*` to it.

## Test plan
- Reset then `req`=0001 at cycle 40, `data_in[0]`=16'd12345 → `conv_wr` low exactly one cycle; `done`=0001 35 cycles after the grant; `result`=21'h012345; `result_ch`=0.
- `req`=1111 held, operands 0, 16'hFFFF, 16'h8000, 16'd32767 → grants in order 0,1,2,3,0; results 21'h000000, 21'h100001, 21'h132768, 21'h032767.
- `req`=0100 for a single cycle, then dropped → `done`=0100 still pulses; no further grant.
- Pulse `rst_n` low during WAIT → outputs return to reset values; no `done`; `conv_wr` stays high for 34 cycles before any new grant.
- `req[1]` and `req[2]` rise together with the pointer at 2 → channel 2 is served first, then channel 1.
- Scoreboard check: `conv_wr` is never low on two cycles less than 36 apart, and `busy` is high from the grant until the `done` edge.

Source files
------------

// File: rtl/neptune_ui_pkg.sv
// Shared definitions for the front-panel user-interface blocks.
//   - Scheduler FSM state encoding (plain 2-bit constants).
//   - BCD_OUT_W: width of the binary-to-BCD converter output
//     {sign, five, four, three, two, one}.
//   - conv_lat(width): converter latency from sampling wr low to a
//     sampleable result.
package neptune_ui_pkg;

  localparam int BCD_OUT_W = 21;

  localparam logic [1:0] ST_FLUSH = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  function automatic int conv_lat(input int width);
    return 2 * width + 2;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   ptr       in   CHW   channel with highest priority this cycle
//   req       in   NREQ  request levels
//   grant     out  NREQ  one-hot grant (all zero when no request)
//   grant_idx out  CHW   encoded grant index
//   any       out  1     at least one request present
// Search order is ptr, ptr+1, ... wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int CHW = $clog2(NREQ)
) (
  input  logic [CHW-1:0]  ptr,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [CHW-1:0]  grant_idx,
  output logic            any
);

  always_comb begin
    int idx;
    logic [CHW-1:0] sel;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    sel       = '0;
    // Walk offsets from farthest to nearest so the nearest request to
    // the pointer is the last one written and therefore wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = CHW'(idx);
      if (req[sel]) begin
        any       = 1'b1;
        grant_idx = sel;
      end
    end
    grant[grant_idx] = any;
  end

endmodule

// File: rtl/bcd_scheduler.sv
// Round-robin scheduler sharing one binary-to-BCD converter among NREQ
// front-panel sources.
//   clk, rst_n  clock, asynchronous active-low reset
//   req         per-channel request level, held until its done pulse
//   data_in     channel i operand at [i*WIDTH +: WIDTH]
//   done        one-cycle pulse on the channel owning result
//   result      last captured converter output, held until next capture
//   result_ch   channel tag of result
//   busy        high whenever the FSM is not IDLE
//   conv_wr     registered active-low start strobe to the converter
//   conv_data   registered operand to the converter
//   conv_res    converter output
// Handshake: a requester raises req[i] and keeps it high; the scheduler
// answers with exactly one done[i] pulse per grant. Dropping req[i] after
// the grant does not cancel it. A req still high after done is served
// again only when the round-robin pointer comes back around.
module bcd_scheduler
  import neptune_ui_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  localparam int CONV_LAT = conv_lat(WIDTH),
  localparam int CHW      = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data_in,
  output logic [NREQ-1:0]       done,
  output logic [BCD_OUT_W-1:0]  result,
  output logic [CHW-1:0]        result_ch,
  output logic                  busy,
  output logic                  conv_wr,
  output logic [WIDTH-1:0]      conv_data,
  input  logic [BCD_OUT_W-1:0]  conv_res
);

  localparam int CNT_W = $clog2(CONV_LAT);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CONV_LAT - 1);

  logic [1:0]           state_q, state_d;
  logic [CHW-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHW-1:0]       tag_q, tag_d;
  logic                 conv_wr_q, conv_wr_d;
  logic [WIDTH-1:0]     conv_data_q, conv_data_d;
  logic [NREQ-1:0]      done_q, done_d;
  logic [BCD_OUT_W-1:0] result_q, result_d;
  logic [CHW-1:0]       result_ch_q, result_ch_d;

  logic [NREQ-1:0]  grant;
  logic [CHW-1:0]   grant_idx;
  logic             grant_any;
  logic [WIDTH-1:0] sel_data;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .ptr       (ptr_q),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  // Operand mux with constant slice bases.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) sel_data = data_in[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    tag_d       = tag_q;
    conv_wr_d   = conv_wr_q;
    conv_data_d = conv_data_q;
    done_d      = '0;
    result_d    = result_q;
    result_ch_d = result_ch_q;
    case (state_q)
      // The converter has no reset; wait out any conversion that may
      // have been in flight when we were reset.
      ST_FLUSH: begin
        conv_wr_d = 1'b1;
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_IDLE: begin
        if (grant_any) begin
          conv_data_d = sel_data;
          tag_d       = grant_idx;
          conv_wr_d   = 1'b0;
          state_d     = ST_ISSUE;
          ptr_d       = (grant_idx == CHW'(NREQ - 1)) ? '0 : grant_idx + CHW'(1);
        end
      end
      ST_ISSUE: begin
        conv_wr_d = 1'b1;
        cnt_d     = CNT_INIT;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          result_d      = conv_res;
          result_ch_d   = tag_q;
          done_d[tag_q] = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_FLUSH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FLUSH;
      ptr_q       <= '0;
      cnt_q       <= CNT_INIT;
      tag_q       <= '0;
      conv_wr_q   <= 1'b1;
      conv_data_q <= '0;
      done_q      <= '0;
      result_q    <= '0;
      result_ch_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      tag_q       <= tag_d;
      conv_wr_q   <= conv_wr_d;
      conv_data_q <= conv_data_d;
      done_q      <= done_d;
      result_q    <= result_d;
      result_ch_q <= result_ch_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign conv_wr   = conv_wr_q;
  assign conv_data = conv_data_q;
  assign done      = done_q;
  assign result    = result_q;
  assign result_ch = result_ch_q;

endmodule

// File: tb/tb_bcd_scheduler.sv
// Testbench for bcd_scheduler with a behavioural converter model.
module tb_bcd_scheduler;

  localparam int WIDTH = 16;
  localparam int NREQ  = 4;
  localparam int CHW   = 2;
  localparam int BW    = 21;
  localparam int EW    = CHW + BW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data_in;
  logic [NREQ-1:0]       done;
  logic [BW-1:0]         result;
  logic [CHW-1:0]        result_ch;
  logic                  busy;
  logic                  conv_wr;
  logic [WIDTH-1:0]      conv_data;
  logic [BW-1:0]         conv_res = '0;

  bcd_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_in   (data_in),
    .done      (done),
    .result    (result),
    .result_ch (result_ch),
    .busy      (busy),
    .conv_wr   (conv_wr),
    .conv_data (conv_data),
    .conv_res  (conv_res)
  );

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [BW-1:0] to_bcd(input logic [15:0] v);
    int u;
    u = v[15] ? 65536 - int'(v) : int'(v);
    return {v[15], 4'(u / 10000), 4'((u / 1000) % 10), 4'((u / 100) % 10),
            4'((u / 10) % 10), 4'(u % 10)};
  endfunction

  // ---------------- converter model ----------------
  // Samples wr low on a rising edge; output is garbage until 34 edges
  // after that sample, then holds the converted value.
  logic [5:0]    m_cnt = '0;
  logic [BW-1:0] m_val = '0;
  always @(posedge clk) begin
    if (!conv_wr) begin
      conv_res <= 21'h1ABCDE;
      m_val    <= to_bcd(conv_data);
      m_cnt    <= 6'd33;
    end else if (m_cnt != 6'd0) begin
      m_cnt <= m_cnt - 6'd1;
      if (m_cnt == 6'd1) conv_res <= m_val;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [EW-1:0] exp_q[$];
  int last_wr_cyc = -1000;
  bit in_flight = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_flight <= 1'b0;
    end else begin
      if (!conv_wr) begin
        check("wr_spacing_ge_36", 32'((cyc - last_wr_cyc) >= 36), 32'd1);
        check("busy_at_issue", 32'(busy), 32'd1);
        check("conv_not_busy_at_start", 32'(m_cnt), 32'd0);
        last_wr_cyc <= cyc;
        in_flight   <= 1'b1;
      end else if (in_flight && done == '0) begin
        check("busy_in_flight", 32'(busy), 32'd1);
      end
      if (done != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          check("done_onehot", 32'(done), 32'd1 << exp_q[0][EW-1 -: CHW]);
          check("result_ch", 32'(result_ch), 32'(exp_q[0][EW-1 -: CHW]));
          check("result", 32'(result), 32'(exp_q[0][BW-1:0]));
          check("done_latency", 32'(cyc - last_wr_cyc), 32'd35);
          void'(exp_q.pop_front());
        end
        in_flight <= 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [WIDTH-1:0] v);
    data_in[ch*WIDTH +: WIDTH] = v;
  endtask

  task automatic push_exp(input int ch, input logic [BW-1:0] r);
    exp_q.push_back({CHW'(ch), r});
  endtask

  task automatic wait_done_drop(input int ch, input int max);
    int n = 0;
    while (!done[ch] && n < max) begin
      tick();
      n++;
    end
    check("done_seen", 32'(done[ch]), 32'd1);
    req[ch] = 1'b0;
  endtask

  task automatic wait_empty(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      tick();
      n++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_values();
    check("rst_conv_wr", 32'(conv_wr), 32'd1);
    check("rst_conv_data", 32'(conv_data), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_result_ch", 32'(result_ch), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int            ch;
    logic [15:0]   operand;
    logic [BW-1:0] exp_res;
  } vec_t;

  vec_t vecs[6];

  // ---------------- main sequence ----------------
  initial begin
    int rst_cyc;
    int mark;
    int n;

    vecs[0] = '{1, 16'd9999, 21'h009999};
    vecs[1] = '{2, 16'hCFC7, 21'h112345};
    vecs[2] = '{3, 16'd100,  21'h000100};
    vecs[3] = '{0, 16'h8001, 21'h132767};
    vecs[4] = '{2, 16'd1,    21'h000001};
    vecs[5] = '{1, 16'hFFF6, 21'h100010};

    req     = '0;
    data_in = '0;
    rst_n   = 1'b0;
    repeat (2) tick();
    check_reset_values();

    // Flush length after reset release.
    @(negedge clk);
    rst_n   = 1'b1;
    rst_cyc = cyc;
    while (cyc < rst_cyc + 33) tick();
    check("flush_busy_edge33", 32'(busy), 32'd1);
    check("flush_wr_high", 32'(conv_wr), 32'd1);
    tick();
    check("idle_at_edge34", 32'(busy), 32'd0);

    // First conversion: grant at edge 40.
    while (cyc < 39) tick();
    set_data(0, 16'd12345);
    push_exp(0, 21'h012345);
    req[0] = 1'b1;
    wait_done_drop(0, 60);
    check("t1_grant_edge", 32'(last_wr_cyc), 32'd40);

    // Table-driven single-channel conversions.
    for (int i = 0; i < 6; i++) begin
      set_data(vecs[i].ch, vecs[i].operand);
      push_exp(vecs[i].ch, vecs[i].exp_res);
      req[vecs[i].ch] = 1'b1;
      wait_done_drop(vecs[i].ch, 60);
    end

    // Reset during WAIT: aborted grant gives no done; request still high
    // is served again after a full flush.
    set_data(3, 16'd4321);
    push_exp(3, 21'h004321);
    req[3] = 1'b1;
    n = 0;
    while (conv_wr && n < 10) begin
      tick();
      n++;
    end
    check("abort_grant_seen", 32'(conv_wr), 32'd0);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check_reset_values();
    exp_q.delete();
    push_exp(3, 21'h004321);
    repeat (2) tick();
    @(negedge clk);
    rst_n   = 1'b1;
    rst_cyc = cyc;
    n = 0;
    while (last_wr_cyc <= rst_cyc && n < 60) begin
      tick();
      n++;
    end
    check("reflush_grant_edge", 32'(last_wr_cyc - rst_cyc), 32'd35);
    wait_done_drop(3, 60);

    // All four requesting with pointer at 0: grants 0,1,2,3,0.
    set_data(0, 16'd0);
    set_data(1, 16'hFFFF);
    set_data(2, 16'h8000);
    set_data(3, 16'd32767);
    push_exp(0, 21'h000000);
    push_exp(1, 21'h100001);
    push_exp(2, 21'h132768);
    push_exp(3, 21'h032767);
    push_exp(0, 21'h000000);
    req = 4'b1111;
    wait_empty(5 * 40);
    req = '0;

    // Single-cycle request still completes; no further grant.
    set_data(2, 16'd2468);
    push_exp(2, 21'h002468);
    req = 4'b0100;
    tick();
    req = '0;
    wait_empty(60);
    mark = last_wr_cyc;
    repeat (80) tick();
    check("no_regrant", 32'(last_wr_cyc), 32'(mark));
    check("idle_after_drop", 32'(busy), 32'd0);

    // Move pointer to 2, then raise req[1] and req[2] together.
    set_data(1, 16'd55);
    push_exp(1, 21'h000055);
    req[1] = 1'b1;
    wait_done_drop(1, 60);
    set_data(1, 16'd111);
    set_data(2, 16'd222);
    push_exp(2, 21'h000222);
    push_exp(1, 21'h000111);
    req = 4'b0110;
    wait_done_drop(2, 60);
    wait_done_drop(1, 80);
    repeat (5) tick();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
